// File: rtl/types_pkg.sv
// Types shared by the memory-port arbiter and the blocks that sit beside it in Top.
package types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage. Data wins
// ties until it has held off a waiting fetch for MAX_DSTREAK consecutive grants.
module mem_port_arbiter
    import types_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN/8-1:0] d_be,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              stall_i,
    output logic              stall_d
);

    localparam int                  BE_W       = XLEN / 8;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_next;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_done;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [XLEN-1:0]     r_mem_addr;
    logic [XLEN-1:0]     r_mem_wdata;

    always_comb begin
        w_state_next  = r_state;
        w_streak_next = r_streak;
        w_grant_i     = 1'b0;
        w_grant_d     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req && d_req) begin
                    if (r_streak == STREAK_MAX) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (i_req) begin
                    w_grant_i = 1'b1;
                end else if (d_req) begin
                    w_grant_d = 1'b1;
                end

                if (w_grant_i) begin
                    w_state_next = BUSY_I;
                end else if (w_grant_d) begin
                    w_state_next = BUSY_D;
                end

                // The streak only measures how long a fetch has actually been kept waiting.
                if (!i_req || w_grant_i) begin
                    w_streak_next = '0;
                end else if (w_grant_d && (r_streak < STREAK_MAX)) begin
                    w_streak_next = r_streak + STREAK_W'(1);
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state   <= w_state_next;
            r_streak  <= w_streak_next;
            r_mem_req <= (w_state_next != IDLE);
            if (w_grant_i) begin
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= '0;
            end else if (w_grant_d) begin
                r_mem_we    <= d_we;
                r_mem_be    <= d_be;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end
        end
    end

    // A completion seen while reset is low is dropped; the requester re-issues.
    assign w_done = mem_ready & reset;

    assign i_valid = (r_state == BUSY_I) & w_done;
    assign d_valid = (r_state == BUSY_D) & w_done;
    assign i_rdata = i_valid ? mem_rdata : '0;
    assign d_rdata = d_valid ? mem_rdata : '0;

    assign stall_i = i_req & ~i_valid;
    assign stall_d = d_req & ~d_valid;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run of mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;
    localparam int MAXS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_rdata;
    logic            i_valid;
    logic            d_req;
    logic            d_we;
    logic [BE_W-1:0] d_be;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_rdata;
    logic            d_valid;
    logic            mem_req;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            stall_i;
    logic            stall_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .MAX_DSTREAK(MAXS)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_valid   (i_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_i   (stall_i),
        .stall_d   (stall_d)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] memarr [32];

    // Reference model: who owns the port, how long fetch has waited, and the granted command.
    int          m_owner;
    int          m_streak;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [3:0]  m_be;

    logic        last_iv = 1'b0;
    logic        last_dv = 1'b0;
    logic        prev_wait = 1'b0;
    int          n_iv = 0;
    int          n_dv = 0;
    logic [31:0] last_i_rdata = 32'h0;
    int          grant_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'({a[13], a[5:2]});
    endfunction

    // Memory side of the bench: returns the stored word when it completes an access.
    task automatic set_mem(input logic rdy);
        mem_ready = rdy;
        if (rdy && (mem_req === 1'b1)) mem_rdata = memarr[idx(mem_addr)];
        else                           mem_rdata = $urandom;
    endtask

    task automatic cycle();
        logic        exp_iv;
        logic        exp_dv;
        logic [31:0] exp_drd;
        int          win;
        @(negedge clk);
        exp_iv = (m_owner == 1) && mem_ready && reset;
        exp_dv = (m_owner == 2) && mem_ready && reset;
        check("mem_req", mem_req, m_owner != 0);
        if (m_owner != 0) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", mem_we, m_we);
            check("mem_be", mem_be, m_be);
            if (m_owner == 2) check("mem_wdata", mem_wdata, m_wdata);
        end
        check("i_valid", i_valid, exp_iv);
        check("d_valid", d_valid, exp_dv);
        check("i_rdata", i_rdata, exp_iv ? memarr[idx(m_addr)] : 32'h0);
        if (exp_dv && !m_we) exp_drd = memarr[idx(m_addr)];
        else if (exp_dv)     exp_drd = mem_rdata;
        else                 exp_drd = 32'h0;
        check("d_rdata", d_rdata, exp_drd);
        check("stall_i", stall_i, i_req && !exp_iv);
        check("stall_d", stall_d, d_req && !exp_dv);

        if (mem_req && !prev_wait) grant_q.push_back(mem_addr[13] ? 2 : 1);
        prev_wait = mem_req && !mem_ready && reset;
        if (i_valid) begin
            n_iv++;
            last_i_rdata = i_rdata;
        end
        if (d_valid) n_dv++;
        last_iv = exp_iv;
        last_dv = exp_dv;

        if (mem_req && mem_ready && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) memarr[idx(mem_addr)][8*b +: 8] = mem_wdata[8*b +: 8];
        end

        if (!reset) begin
            m_owner  = 0;
            m_streak = 0;
        end else if (m_owner == 0) begin
            win = 0;
            if (i_req && d_req) win = (m_streak == MAXS) ? 1 : 2;
            else if (i_req)     win = 1;
            else if (d_req)     win = 2;
            if (!i_req || win == 1)  m_streak = 0;
            else if (m_streak < MAXS) m_streak++;
            if (win == 1) begin
                m_addr = i_addr;
                m_we   = 1'b0;
                m_be   = 4'hF;
            end else if (win == 2) begin
                m_addr  = d_addr;
                m_we    = d_we;
                m_be    = d_be;
                m_wdata = d_wdata;
            end
            m_owner = win;
        end else if (mem_ready) begin
            m_owner = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_g[6] = '{2, 2, 2, 2, 1, 2};

        for (int k = 0; k < 32; k++) memarr[k] = $urandom;
        reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        m_owner = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_be = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_i_valid", i_valid, 1'b0);
        check("rst_d_valid", d_valid, 1'b0);
        reset = 1'b1;

        // Single fetch answered in the first memory cycle.
        memarr[idx(32'h100)] = 32'h0050_0093;
        n_iv = 0;
        i_req = 1'b1; i_addr = 32'h100;
        set_mem(1'b0); cycle();
        check("fetch_addr", mem_addr, 32'h100);
        set_mem(1'b1); cycle();
        i_req = 1'b0;
        set_mem(1'b0); cycle(); cycle();
        check("fetch_pulses", n_iv, 1);
        check("fetch_data", last_i_rdata, 32'h0050_0093);

        // Store held off by three wait states.
        n_dv = 0;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        set_mem(1'b0); cycle();
        repeat (3) begin
            set_mem(1'b0); cycle();
        end
        set_mem(1'b1); cycle();
        d_req = 1'b0;
        set_mem(1'b0); cycle();
        check("store_pulses", n_dv, 1);
        check("store_mem", memarr[idx(32'h2000)], 32'hDEAD_BEEF);

        // Continuous contention: four data grants, then the fetch gets through.
        d_we = 1'b0; d_addr = 32'h2004; i_addr = 32'h108;
        i_req = 1'b1; d_req = 1'b1;
        grant_q.delete();
        repeat (14) begin
            set_mem(1'b1); cycle();
        end
        i_req = 1'b0; d_req = 1'b0;
        set_mem(1'b0); cycle();
        check("contend_grants", grant_q.size() >= 6, 1'b1);
        for (int k = 0; k < 6; k++) check($sformatf("contend_grant%0d", k), grant_q[k], exp_g[k]);

        // Reset while a load is waiting on memory.
        n_dv = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008;
        set_mem(1'b0); cycle();
        set_mem(1'b0); cycle();
        reset = 1'b0;
        set_mem(1'b1); cycle();
        check("rstmid_mem_req", mem_req, 1'b0);
        reset = 1'b1; d_req = 1'b0;
        set_mem(1'b0); cycle();
        check("rstmid_no_dvalid", n_dv, 0);

        // Fetch request dropped mid-access still completes; pending store goes next.
        n_iv = 0;
        grant_q.delete();
        i_req = 1'b1; i_addr = 32'h10C;
        set_mem(1'b0); cycle();
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h200C; d_wdata = $urandom;
        set_mem(1'b0); cycle();
        set_mem(1'b1); cycle();
        check("drop_ivalid", n_iv, 1);
        set_mem(1'b0); cycle();
        set_mem(1'b1); cycle();
        d_req = 1'b0;
        set_mem(1'b0); cycle();
        check("drop_grants", grant_q.size(), 2);
        check("drop_first", grant_q[0], 1);
        check("drop_second", grant_q[1], 2);

        // Randomized traffic, wait states, stray mem_ready and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            if (!i_req || last_iv) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
            end
            if (!d_req || last_dv) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom_range(1, 15));
                d_addr  = 32'h2000 + 32'(4 * $urandom_range(0, 15));
                d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 63) != 0);
            set_mem(1'($urandom_range(0, 1)));
            cycle();
        end
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        set_mem(1'b1); cycle();
        set_mem(1'b0); cycle();
        check("final_idle", mem_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
